mem_port_arbiter: RTL and testbench

Shares the single unified byte-addressable `Memory` (data region 0x0000–0x0FFF, instruction region 0x1000–0x1FFF, little-endian words) between the instruction-fetch requester and the load/store requester. It runs a req/gnt/rvalid handshake on each side. It sequences each memory access over a fixed latency, and blocks illegal accesses before they reach the array. It sits between the CPU front end and data stage on one side and the `Memory` ports on the other.

---
 rtl/mem_arb_pkg.sv | 42 ++++
 rtl/mem_addr_check.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
//   Shared definitions for the memory port arbiter:
//     - arbiter FSM state encoding
//     - default memory map (instruction base, total size)
//     - access-owner encoding (fetch vs. load/store)
//     - error-cause codes produced by the address legality check
//     - small helper for word alignment
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  // Default memory map: data 0x0000-0x0FFF, instructions 0x1000-0x1FFF.
  localparam logic [31:0] INST_BASE_DEF = 32'h0000_1000;
  localparam logic [31:0] MEM_SIZE_DEF  = 32'h0000_2000;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  // Why an access was refused. Only "none vs. anything else" leaves the
  // checker today; the finer causes keep the rule set readable.
  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_MISALIGN   = 3'd1,
    ERR_RANGE      = 3'd2,
    ERR_FETCH_DATA = 3'd3,
    ERR_LOAD_INST  = 3'd4,
    ERR_STORE_INST = 3'd5
  } err_cause_t;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mem_addr_check.sv
// ---------------------------------------------------------------------------
// mem_addr_check
//   Combinational legality check for the access that is about to be granted.
//   Ports:
//     addr     in  32 : byte address of the winning requester
//     is_fetch in  1  : 1 = instruction fetch, 0 = load/store
//     we       in  1  : 1 = store (only meaningful for data accesses)
//     illegal  out 1  : access must not reach the memory array
// ---------------------------------------------------------------------------
module mem_addr_check
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] INST_BASE = INST_BASE_DEF,
  parameter logic [31:0] MEM_SIZE  = MEM_SIZE_DEF
) (
  input  logic [31:0] addr,
  input  logic        is_fetch,
  input  logic        we,
  output logic        illegal
);

  err_cause_t cause;

  // Rules are checked in priority order; the first that fires names the cause.
  always_comb begin
    cause = ERR_NONE;
    if (!is_word_aligned(addr)) begin
      cause = ERR_MISALIGN;
    end else if (addr >= MEM_SIZE) begin
      cause = ERR_RANGE;
    end else if (is_fetch && (addr < INST_BASE)) begin
      cause = ERR_FETCH_DATA;
    end else if (!is_fetch && (addr >= INST_BASE)) begin
      cause = we ? ERR_STORE_INST : ERR_LOAD_INST;
    end
  end

  assign illegal = (cause != ERR_NONE);

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one unified byte-addressable memory between the instruction-fetch
//   port and the load/store port. Each side uses a req/gnt/rvalid handshake;
//   one access is in flight at a time and is sequenced over MEM_LAT cycles.
//   Illegal accesses are answered with an error and never touch the array.
//
//   Ports:
//     clk, rst_n                  : clock, asynchronous active-low reset
//     if_req, if_addr             : fetch request / address
//     if_gnt, if_rvalid           : fetch grant pulse / response pulse
//     if_rdata, if_err            : fetch response data / error (0 unless rvalid)
//     d_req, d_we, d_addr, d_wdata: data request, store flag, address, store data
//     d_gnt, d_rvalid             : data grant pulse / response (also store done)
//     d_rdata, d_err              : data response data / error (0 unless rvalid)
//     m_addr, m_wdata             : memory address / write data (0 when idle)
//     m_read, m_write             : memory strobes
//     m_rdata                     : memory read data
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4,
  parameter logic [31:0] INST_BASE  = INST_BASE_DEF,
  parameter logic [31:0] MEM_SIZE   = MEM_SIZE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_read,
  output logic        m_write,
  input  logic [31:0] m_rdata
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam int unsigned LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [LW-1:0] LAT_LAST   = LW'(MEM_LAT - 1);

  arb_state_t    state;
  arb_state_t    state_nxt;
  owner_t        owner;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [SW-1:0] starve_cnt;
  logic [LW-1:0] lat_cnt;

  logic          win_if;
  logic          win_d;
  logic [31:0]   win_addr;
  logic          win_we;
  logic          win_illegal;
  logic          lat_last;

  // -------------------------------------------------------------------------
  // Arbitration: only evaluated while idle. Data has priority, except that
  // once STARVE_MAX data grants have gone by with fetch waiting, fetch wins.
  // -------------------------------------------------------------------------
  always_comb begin
    win_if = 1'b0;
    win_d  = 1'b0;
    if (state == ST_IDLE) begin
      if (if_req && (!d_req || (starve_cnt == STARVE_LIM))) begin
        win_if = 1'b1;
      end else if (d_req) begin
        win_d = 1'b1;
      end
    end
  end

  assign win_addr = win_if ? if_addr : d_addr;
  assign win_we   = win_d & d_we;

  mem_addr_check #(
    .INST_BASE (INST_BASE),
    .MEM_SIZE  (MEM_SIZE)
  ) u_addr_check (
    .addr     (win_addr),
    .is_fetch (win_if),
    .we       (win_we),
    .illegal  (win_illegal)
  );

  assign lat_last = (lat_cnt == LAT_LAST);

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and control strobes. Grants are combinational so they appear
  // in the same cycle the request is sampled; they are gated with rst_n so a
  // held request cannot produce a grant while reset is asserted.
  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    m_read    = 1'b0;
    m_write   = 1'b0;
    case (state)
      ST_IDLE: begin
        if_gnt = rst_n & win_if;
        d_gnt  = rst_n & win_d;
        if (win_if || win_d) begin
          state_nxt = win_illegal ? ST_RESP : ST_BUSY;
        end
      end
      ST_BUSY: begin
        m_read  = ~we_q;
        // Write strobe stays low on the first BUSY cycle so address and data
        // are already stable when it rises.
        m_write = we_q & (lat_cnt != '0);
        if (lat_last) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if_rvalid = (owner == OWN_IF);
        d_rvalid  = (owner == OWN_D);
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Access registers: captured at the grant edge, held through RESP, then
  // cleared so the memory side reads 0 while idle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner   <= OWN_IF;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_if || win_d) begin
            owner   <= win_if ? OWN_IF : OWN_D;
            we_q    <= win_we;
            addr_q  <= win_addr;
            wdata_q <= win_we ? d_wdata : '0;
            rdata_q <= '0;
            err_q   <= win_illegal;
          end
        end
        ST_BUSY: begin
          if (lat_last && !we_q) begin
            rdata_q <= m_rdata;
          end
        end
        ST_RESP: begin
          we_q    <= 1'b0;
          addr_q  <= '0;
          wdata_q <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Latency counter: 0 .. MEM_LAT-1 across the BUSY cycles, 0 otherwise.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt <= '0;
    end else if (state == ST_BUSY && !lat_last) begin
      lat_cnt <= lat_cnt + 1'b1;
    end else begin
      lat_cnt <= '0;
    end
  end

  // -------------------------------------------------------------------------
  // Starvation counter: counts data grants taken while fetch was waiting.
  // A data grant with no fetch pending, or any fetch grant, restarts it.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (win_d) begin
      if (!if_req) begin
        starve_cnt <= '0;
      end else if (starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end else if (win_if) begin
      starve_cnt <= '0;
    end
  end

  // Response data and error are only driven while the owner's rvalid is high.
  assign if_rdata = if_rvalid ? rdata_q : '0;
  assign if_err   = if_rvalid & err_q;
  assign d_rdata  = d_rvalid ? rdata_q : '0;
  assign d_err    = d_rvalid & err_q;

  assign m_addr   = addr_q;
  assign m_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Scoreboard bench for mem_port_arbiter: drivers push the expected response
//   of every request into a per-port queue (computed from a word-level model
//   of the memory map), and a monitor pops and compares on every rvalid.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int          MEM_LAT    = 2;
  localparam int          STARVE_MAX = 4;
  localparam logic [31:0] INST_BASE  = 32'h0000_1000;
  localparam logic [31:0] MEM_SIZE   = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_read, m_write;

  mem_port_arbiter #(
    .MEM_LAT    (MEM_LAT),
    .STARVE_MAX (STARVE_MAX),
    .INST_BASE  (INST_BASE),
    .MEM_SIZE   (MEM_SIZE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .if_err    (if_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_read    (m_read),
    .m_write   (m_write),
    .m_rdata   (m_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    logic        store;
  } resp_t;

  resp_t       if_q[$];
  resp_t       d_q[$];
  bit          gnt_log[$];          // 1 = fetch grant, 0 = data grant
  logic [31:0] ref_words [logic [31:0]];
  logic [7:0]  mem [0:8191];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int gnt_cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  logic mw_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte-array memory, little-endian, read combinationally.
  always_comb begin
    logic [12:0] a;
    a = m_addr[12:0];
    m_rdata = '0;
    if (m_addr <= 32'd8188) m_rdata = {mem[a + 13'd3], mem[a + 13'd2], mem[a + 13'd1], mem[a]};
  end

  function automatic void put_word(input logic [31:0] addr, input logic [31:0] w);
    logic [12:0] a;
    a = addr[12:0];
    mem[a]          = w[7:0];
    mem[a + 13'd1]  = w[15:8];
    mem[a + 13'd2]  = w[23:16];
    mem[a + 13'd3]  = w[31:24];
  endfunction

  // Reference: memory map rules and a word store.
  function automatic bit legal(input logic [31:0] addr, input bit fetch);
    if ((addr % 4) != 0) return 1'b0;
    if (addr >= MEM_SIZE) return 1'b0;
    if (fetch) return (addr >= INST_BASE);
    return (addr < INST_BASE);
  endfunction

  function automatic resp_t model(input logic [31:0] addr, input bit fetch, input logic we,
                                  input logic [31:0] wdata);
    resp_t r;
    r.addr  = addr;
    r.store = we;
    r.err   = 1'b0;
    r.data  = '0;
    if (!legal(addr, fetch)) begin
      r.err = 1'b1;
    end else if (we) begin
      ref_words[addr] = wdata;
    end else begin
      r.data = ref_words[addr];
    end
    return r;
  endfunction

  task automatic check_resp(input string side, input resp_t e, input logic [31:0] rdata,
                            input logic err);
    int lat_req;
    int rd_req;
    int wr_req;
    lat_req = e.err ? 1 : MEM_LAT + 1;
    rd_req  = (!e.err && !e.store) ? MEM_LAT : 0;
    wr_req  = (!e.err && e.store) ? 1 : 0;
    n_chk++;
    if (rdata !== e.data) begin
      n_fail++;
      $display("FAIL %s_rdata addr=%h got %h expected %h", side, e.addr, rdata, e.data);
    end
    n_chk++;
    if (err !== e.err) begin
      n_fail++;
      $display("FAIL %s_err addr=%h got %b expected %b", side, e.addr, err, e.err);
    end
    n_chk++;
    if ((cyc - gnt_cyc) != lat_req) begin
      n_fail++;
      $display("FAIL %s_latency addr=%h got %0d expected %0d", side, e.addr, cyc - gnt_cyc, lat_req);
    end
    n_chk++;
    if (m_addr !== e.addr) begin
      n_fail++;
      $display("FAIL %s_m_addr_hold got %h expected %h", side, m_addr, e.addr);
    end
    n_chk++;
    if (rd_cnt != rd_req || wr_cnt != wr_req) begin
      n_fail++;
      $display("FAIL %s_mem_activity addr=%h reads %0d writes %0d expected reads %0d writes %0d",
               side, e.addr, rd_cnt, wr_cnt, rd_req, wr_req);
    end
  endtask

  // Monitor: memory side model, grant bookkeeping and response scoreboard.
  always @(negedge clk) begin
    resp_t e;
    if (!rst_n) begin
      mw_prev = 1'b0;
    end else begin
      if (if_gnt || d_gnt) begin
        n_chk++;
        if (if_gnt && d_gnt) begin
          n_fail++;
          $display("FAIL dual_gnt got both grants expected one");
        end
        n_chk++;
        if (m_addr !== 32'h0 || m_read !== 1'b0 || m_write !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_mem_side m_addr=%h m_read=%b m_write=%b expected all 0", m_addr, m_read, m_write);
        end
        gnt_cyc = cyc;
        rd_cnt  = 0;
        wr_cnt  = 0;
        gnt_log.push_back(if_gnt);
      end
      if (m_read) rd_cnt++;
      if (m_write && !mw_prev) begin
        wr_cnt++;
        if (m_addr <= 32'd8188) put_word(m_addr, m_wdata);
      end
      mw_prev = m_write;

      n_chk++;
      if ((!if_rvalid && (if_rdata !== 32'h0 || if_err !== 1'b0)) ||
          (!d_rvalid && (d_rdata !== 32'h0 || d_err !== 1'b0))) begin
        n_fail++;
        $display("FAIL resp_idle_zero if_rdata=%h if_err=%b d_rdata=%h d_err=%b expected 0 outside rvalid",
                 if_rdata, if_err, d_rdata, d_err);
      end

      if (if_rvalid) begin
        n_chk++;
        if (if_q.size() == 0) begin
          n_fail++;
          $display("FAIL if_unexpected_rvalid got rvalid expected none");
        end else begin
          e = if_q.pop_front();
          check_resp("if", e, if_rdata, if_err);
        end
      end
      if (d_rvalid) begin
        n_chk++;
        if (d_q.size() == 0) begin
          n_fail++;
          $display("FAIL d_unexpected_rvalid got rvalid expected none");
        end else begin
          e = d_q.pop_front();
          check_resp("d", e, d_rdata, d_err);
        end
      end
    end
  end

  // Drivers: raise req, wait (bounded) for gnt, return in the following cycle
  // with req still asserted so the caller may chain or drop it.
  task automatic d_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input bit push);
    bit got = 1'b0;
    int n = 0;
    if (push) d_q.push_back(model(addr, 1'b0, we, wdata));
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    while (!got && n < 200) begin
      @(negedge clk);
      if (d_gnt) got = 1'b1;
      n++;
    end
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL d_gnt_timeout addr=%h got no grant expected grant within 200 cycles", addr);
      d_req = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic if_access(input logic [31:0] addr);
    bit got = 1'b0;
    int n = 0;
    if_q.push_back(model(addr, 1'b1, 1'b0, 32'h0));
    if_req = 1'b1; if_addr = addr;
    while (!got && n < 200) begin
      @(negedge clk);
      if (if_gnt) got = 1'b1;
      n++;
    end
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL if_gnt_timeout addr=%h got no grant expected grant within 200 cycles", addr);
      if_req = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((if_q.size() != 0 || d_q.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    n_chk++;
    if (if_q.size() != 0 || d_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout pending if=%0d d=%0d expected 0", if_q.size(), d_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    n_chk++;
    if ({if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
         m_addr, m_wdata, m_read, m_write} !== '0) begin
      n_fail++;
      $display("FAIL %s outputs gnt=%b/%b rvalid=%b/%b m_read=%b m_write=%b m_addr=%h expected all 0",
               name, if_gnt, d_gnt, if_rvalid, d_rvalid, m_read, m_write, m_addr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    bit          exp_order [6];
    logic [31:0] saved;

    for (int i = 0; i < 2048; i++) begin
      w = $urandom;
      ref_words[32'(i * 4)] = w;
      put_word(32'(i * 4), w);
    end

    // Reset with both requests held: nothing may leak out.
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 32'h1000;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0; d_wdata = 32'h1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Fetch-only read of a preloaded word.
    ref_words[32'h1000] = 32'h2008_0005;
    put_word(32'h1000, 32'h2008_0005);
    if_access(32'h1000);
    if_req = 1'b0;
    wait_quiet();

    // Store then load back.
    d_access(1'b1, 32'h0010, 32'hDEAD_BEEF, 1'b1);
    d_req = 1'b0;
    wait_quiet();
    d_access(1'b0, 32'h0010, 32'h0, 1'b1);
    d_req = 1'b0;
    wait_quiet();
    n_chk++;
    if (mem[13'h10] !== 8'hEF) begin
      n_fail++;
      $display("FAIL store_byte0 got %h expected ef", mem[13'h10]);
    end

    // Illegal accesses.
    d_access(1'b0, 32'h0012, 32'h0, 1'b1);          d_req = 1'b0;  wait_quiet();
    d_access(1'b1, 32'h1004, 32'h5555_AAAA, 1'b1);  d_req = 1'b0;  wait_quiet();
    if_access(32'h0040);                            if_req = 1'b0; wait_quiet();
    d_access(1'b0, 32'h2000, 32'h0, 1'b1);          d_req = 1'b0;  wait_quiet();
    d_access(1'b1, 32'h2000, 32'h1111_2222, 1'b1);  d_req = 1'b0;  wait_quiet();
    if_access(32'h2000);                            if_req = 1'b0; wait_quiet();
    if_access(32'h1FFC);                            if_req = 1'b0; wait_quiet();

    // Contention: both requesters held high; after STARVE_MAX data grants
    // the fetch side must get the next slot.
    gnt_log.delete();
    fork
      begin
        for (int i = 0; i < 6; i++) d_access(1'b0, 32'h0100 + 32'(4 * i), 32'h0, 1'b1);
        d_req = 1'b0;
      end
      begin
        for (int i = 0; i < 2; i++) if_access(32'h1000 + 32'(4 * i));
        if_req = 1'b0;
      end
    join
    wait_quiet();
    for (int i = 0; i < 6; i++) exp_order[i] = (i == STARVE_MAX);
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (gnt_log.size() <= i || gnt_log[i] != exp_order[i]) begin
        n_fail++;
        $display("FAIL grant_order slot %0d got %s expected %s", i,
                 (gnt_log.size() <= i) ? "none" : (gnt_log[i] ? "IF" : "D"),
                 exp_order[i] ? "IF" : "D");
      end
    end

    // Reset during the first BUSY cycle of a store.
    saved = ref_words[32'h0020];
    d_access(1'b1, 32'h0020, 32'h1234_5678, 1'b0);
    d_req = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_mid_store");
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (wr_cnt != 0) begin
      n_fail++;
      $display("FAIL abandoned_store_write got %0d write edges expected 0", wr_cnt);
    end
    n_chk++;
    if ({mem[13'h23], mem[13'h22], mem[13'h21], mem[13'h20]} !== saved) begin
      n_fail++;
      $display("FAIL abandoned_store_mem got %h expected %h",
               {mem[13'h23], mem[13'h22], mem[13'h21], mem[13'h20]}, saved);
    end
    d_access(1'b0, 32'h0020, 32'h0, 1'b1);
    d_req = 1'b0;
    wait_quiet();

    // Randomised traffic on both ports.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [31:0] a;
          int gap;
          if ($urandom_range(0, 9) == 0) a = $urandom & 32'h0000_3FFF;
          else a = 32'($urandom_range(0, 63) * 4);
          d_access(1'($urandom_range(0, 1)), a, $urandom, 1'b1);
          gap = $urandom_range(0, 3);
          if (gap > 0) begin
            d_req = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
          end
        end
        d_req = 1'b0;
      end
      begin
        for (int i = 0; i < 40; i++) begin
          logic [31:0] a;
          int gap;
          if ($urandom_range(0, 9) == 0) a = $urandom & 32'h0000_3FFF;
          else a = INST_BASE + 32'($urandom_range(0, 1023) * 4);
          if_access(a);
          gap = $urandom_range(0, 3);
          if (gap > 0) begin
            if_req = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
          end
        end
        if_req = 1'b0;
      end
    join
    wait_quiet();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
